// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared state encoding, sizes and length clamp for the stimulus sequencer
package fsm_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int LEN_MAX = 16;
  localparam int RES_W = 6;
  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    return (l > 5'(LEN_MAX)) ? 5'(LEN_MAX) : l;
  endfunction
endpackage

// File: rtl/fsm_stim_sequencer_tick_gen.sv
// tick_gen: enable-tick divider with synchronous clear, one tick every TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CNT_W-1:0] cnt;
  assign tick = en && (cnt == CNT_W'(TICK_DIV - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/fsm_stim_sequencer.sv
// fsm_stim_sequencer: loads a pattern, clears the target FSM, steps it bit-serially and sums its outputs
module fsm_stim_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_MAX-1:0] pattern,
  input  logic [4:0]         len,
  input  logic [1:0]         fsm_out,
  output logic               bit_out,
  output logic               tick_en,
  output logic               fsm_rst_n,
  output logic               busy,
  output logic               done,
  output logic [RES_W-1:0]   result
);
  state_t state, nxt;
  logic [LEN_MAX-1:0] shreg;
  logic [4:0] remaining, len_c;
  logic tick, accept, step;
  assign len_c = clamp_len(len);
  assign accept = (state == IDLE) && start;
  // abort outranks a coincident tick so the target FSM never sees a half-taken step
  assign step = (state == RUN) && tick && !abort;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state != RUN),
    .en  (state == RUN),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = start ? ((len_c == 5'd0) ? DONE : LOAD) : IDLE;
      LOAD: nxt = abort ? IDLE : RUN;
      RUN:  nxt = abort ? IDLE : (step && remaining == 5'd1) ? DONE : RUN;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    bit_out = (state == RUN) && shreg[0];
    tick_en = step;
    fsm_rst_n = (state != LOAD);
    busy = (state == LOAD) || (state == RUN);
    done = (state == DONE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shreg <= '0;
      remaining <= '0;
      result <= '0;
    end else if (accept) begin
      shreg <= pattern;
      remaining <= len_c;
      result <= '0;
    end else if (step) begin
      shreg <= shreg >> 1;
      remaining <= remaining - 5'd1;
      result <= result + {4'b0, fsm_out};
    end
endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// tb_fsm_stim_sequencer: directed and randomized runs against a bit-level reference of run timing and output sums
module tb_fsm_stim_sequencer;
  localparam int TD = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0] len = '0;
  logic [1:0] fsm_out, dst;
  logic bit_out, tick_en, fsm_rst_n, busy, done;
  logic [5:0] result;
  int mode = 0;
  int n_assert = 0, n_fail = 0;

  fsm_stim_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern), .len(len),
    .fsm_out(fsm_out), .bit_out(bit_out), .tick_en(tick_en), .fsm_rst_n(fsm_rst_n),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // target FSM stand-ins: constant 3, echo of the input bit, or a saturating ones-run detector
  always @(posedge clk or negedge rst)
    if (!rst) dst <= 2'd0;
    else if (!fsm_rst_n) dst <= 2'd0;
    else if (tick_en) dst <= bit_out ? ((dst == 2'd3) ? 2'd3 : dst + 2'd1) : 2'd0;

  always_comb
    fsm_out = (mode == 0) ? 2'd3 : (mode == 1) ? {1'b0, bit_out} :
              (bit_out ? ((dst == 2'd3) ? 2'd3 : dst + 2'd1) : 2'd0);

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_sum(input logic [15:0] p, input int n, input int m);
    int s = 0, st = 0, o;
    for (int i = 0; i < n; i++) begin
      if (m == 0) o = 3;
      else if (m == 1) o = int'(p[i]);
      else begin
        o = p[i] ? ((st == 3) ? 3 : st + 1) : 0;
        st = o;
      end
      s += o;
    end
    return s;
  endfunction

  // ab: 1-based tick on which abort is raised (0 = none); inj: pulse start mid-run with a different pattern
  task automatic run(input logic [15:0] p, input int l, input int m, input int ab, input bit inj);
    int ln = (l > 16) ? 16 : l;
    int ticks = (ab > 0) ? ab - 1 : ln;
    int last_busy = (ln == 0) ? 0 : (ab > 0) ? TD * ab + 1 : TD * ln + 1;
    int rl_cnt = 0, rl_first = -1, tk_cnt = 0, tk_pos_err = 0, bit_err = 0, busy_err = 0;
    int dn_cnt = 0, dn_c = -1;
    logic exp_bit;
    mode = m;
    @(negedge clk);
    pattern = p;
    len = 5'(l);
    start = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      start = inj && (c == 6);
      pattern = start ? ~p : p;
      abort = (ab > 0) && (c == TD * ab + 1);
      #1;
      if (!fsm_rst_n) begin
        rl_cnt++;
        if (rl_first < 0) rl_first = c;
      end
      if (tick_en) begin
        tk_cnt++;
        if (c != TD * tk_cnt + 1) tk_pos_err++;
      end
      exp_bit = (c >= 2 && c <= last_busy) ? p[(c - 2) / TD] : 1'b0;
      if (bit_out !== exp_bit) bit_err++;
      if (busy !== (c >= 1 && c <= last_busy)) busy_err++;
      if (done) begin
        dn_cnt++;
        dn_c = c;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    chk("fsm_rst_n_pulses", rl_cnt, (ln > 0) ? 1 : 0);
    chk("fsm_rst_n_cycle", rl_first, (ln > 0) ? 1 : -1);
    chk("tick_count", tk_cnt, ticks);
    chk("tick_spacing_errs", tk_pos_err, 0);
    chk("bit_out_errs", bit_err, 0);
    chk("busy_errs", busy_err, 0);
    chk("done_pulses", dn_cnt, (ab > 0) ? 0 : 1);
    chk("done_cycle", dn_c, (ab > 0) ? -1 : (ln == 0) ? 1 : TD * ln + 2);
    chk("result", int'(result), exp_sum(p, ticks, m));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tick_en"}, int'(tick_en), 0);
    chk({tag, "_fsm_rst_n"}, int'(fsm_rst_n), 1);
    chk({tag, "_bit_out"}, int'(bit_out), 0);
    chk({tag, "_result"}, int'(result), 0);
  endtask

  initial begin
    logic [15:0] rp;
    int rl, rm, rab, rln;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
    run(16'hFFFF, 16, 0, 0, 1'b0);
    run(16'hA5C3, 16, 1, 0, 1'b0);
    run(16'h0003, 2, 2, 0, 1'b0);
    run(16'h1234, 0, 0, 0, 1'b0);
    run(16'hFFFF, 20, 0, 0, 1'b0);
    run(16'h00B7, 8, 1, 3, 1'b1);
    run(16'h0F3D, 8, 2, 0, 1'b1);
    mode = 0;
    @(negedge clk);
    pattern = 16'hFFFF;
    len = 5'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    #4 rst = 1'b1;
    run(16'hC6A9, 16, 2, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rp = 16'($urandom);
      rl = $urandom_range(0, 20);
      rm = $urandom_range(0, 2);
      rln = (rl > 16) ? 16 : rl;
      rab = (rln > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, rln) : 0;
      run(rp, rl, rm, rab, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
